eq_coeff_sched: RTL and testbench

- Sequencer between the SPI coefficient receiver and the three-band (low/mid/high) biquad cascade.
- Takes a full 15-coefficient set on a 1-cycle valid pulse and buffers it.
- Applies the set one band at a time, each band only on an audio sample boundary, with a settle gap between bands.
- Pulses a per-band state clear at each commit, so a retune never glitches mid-sample.

---
 rtl/eq_coeff_sched.sv | 150 +++++++++++++++
 tb/tb_eq_coeff_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_coeff_sched.sv
// eq_coeff_sched: sequences a buffered 15-coefficient biquad set into a
// three-band (low/mid/high) cascade, one band per audio sample boundary,
// with SETTLE_TICKS sample ticks of settle time between band commits.
//
// Ports:
//   clk, reset (sync, active-low)
//   cfg_valid/cfg_coeffs  - new coefficient set (band-major, 5 coeffs/band)
//   sample_tick           - one pulse per audio sample
//   coef_active           - coefficients driven to the filters
//   state_clr[2:0]        - per-band delay-state clear, pulsed on commit
//   busy, pending         - sequence running / shadow holds an unstarted set
//   overwrite             - pending set replaced before it started
//   update_done           - pulse after the high-band commit slot
//   unstable[2:0]         - sticky per-band rejection (COEFF_STAB_CHECK_EN)
//
// Optional feature: define COEFF_STAB_CHECK_EN to reject bands whose
// denominator (a1, a2) lies outside the biquad stability triangle.
module eq_coeff_sched #(
  parameter int COEFF_W       = 16,
  parameter int SETTLE_TICKS  = 2,
  parameter int CLR_ON_UPDATE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  input  logic [15*COEFF_W-1:0]  cfg_coeffs,
  input  logic                   sample_tick,
  output logic [15*COEFF_W-1:0]  coef_active,
  output logic [2:0]             state_clr,
  output logic                   busy,
  output logic                   pending,
  output logic                   overwrite,
  output logic                   update_done,
  output logic [2:0]             unstable
);
  localparam int BAND_W = 5*COEFF_W;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, SETTLE} state_t;

  state_t                  state;
  logic [1:0]              band;
  logic [3:0]              settle_cnt;
  logic [2:0][BAND_W-1:0]  shadow, staging, coef_q;
  logic [2:0][BAND_W-1:0]  pass_set;
  logic                    commit_ok;

  // Passthrough: b0 = 1.0 in Q2.14, everything else zero.
  for (genvar b = 0; b < 3; b++) begin : g_pass
    assign pass_set[b] = BAND_W'(1 << (COEFF_W-2));
  end

  assign coef_active = coef_q;
  assign busy        = (state != IDLE);

`ifdef COEFF_STAB_CHECK_EN
  logic [2:0] unstable_q;
  assign unstable = unstable_q;

  // Stability triangle on the band about to commit, with two guard bits so
  // |a| and 1.0 + a2 cannot overflow.
  logic signed [COEFF_W-1:0] a1, a2;
  logic signed [COEFF_W+1:0] a1x, a2x, abs1, abs2, one;
  always_comb begin
    a1   = staging[band][3*COEFF_W +: COEFF_W];
    a2   = staging[band][4*COEFF_W +: COEFF_W];
    a1x  = {{2{a1[COEFF_W-1]}}, a1};
    a2x  = {{2{a2[COEFF_W-1]}}, a2};
    abs1 = a1x[COEFF_W+1] ? -a1x : a1x;
    abs2 = a2x[COEFF_W+1] ? -a2x : a2x;
    one  = (COEFF_W+2)'(1 << (COEFF_W-2));
    commit_ok = (abs2 < one) && (abs1 < (one + a2x));
  end
`else
  assign unstable  = 3'b000;
  assign commit_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      band        <= 2'd0;
      settle_cnt  <= 4'd0;
      shadow      <= '0;
      staging     <= '0;
      pending     <= 1'b0;
      coef_q      <= pass_set;
      state_clr   <= 3'b000;
      overwrite   <= 1'b0;
      update_done <= 1'b0;
`ifdef COEFF_STAB_CHECK_EN
      unstable_q  <= 3'b000;
`endif
    end else begin
      state_clr   <= 3'b000;
      overwrite   <= 1'b0;
      update_done <= 1'b0;

      if (cfg_valid) shadow <= cfg_coeffs;

      // The IDLE launch edge consumes the old shadow, so a coincident
      // cfg_valid just refills pending instead of counting as an overwrite.
      if (state == IDLE && pending) begin
        pending <= cfg_valid;
      end else if (cfg_valid) begin
        pending   <= 1'b1;
        overwrite <= pending;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            staging <= shadow;
            band    <= 2'd0;
            state   <= WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (sample_tick) begin
            if (commit_ok) begin
              coef_q[band] <= staging[band];
              if (CLR_ON_UPDATE != 0) state_clr[band] <= 1'b1;
`ifdef COEFF_STAB_CHECK_EN
              unstable_q[band] <= 1'b0;
            end else begin
              unstable_q[band] <= 1'b1;
`endif
            end
            if (band == 2'd2) begin
              update_done <= 1'b1;
              state       <= IDLE;
            end else begin
              settle_cnt <= 4'd0;
              state      <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (sample_tick) begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt + 4'd1 == 4'(SETTLE_TICKS)) begin
              band  <= band + 2'd1;
              state <= WAIT_TICK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eq_coeff_sched.sv
module tb_eq_coeff_sched;
  localparam int W = 16;
  localparam int SW = 15*W;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic [SW-1:0] cfg_coeffs;
  logic          sample_tick;
  logic [SW-1:0] coef_active;
  logic [2:0]    state_clr;
  logic          busy, pending, overwrite, update_done;
  logic [2:0]    unstable;

  int errors = 0;
  int checks = 0;

  eq_coeff_sched #(.COEFF_W(W), .SETTLE_TICKS(2), .CLR_ON_UPDATE(1)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_coeffs(cfg_coeffs),
    .sample_tick(sample_tick), .coef_active(coef_active), .state_clr(state_clr),
    .busy(busy), .pending(pending), .overwrite(overwrite),
    .update_done(update_done), .unstable(unstable)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] mk(input int l, input int m, input int h);
    logic [SW-1:0] s;
    s = '0;
    s[0*80 +: 16] = 16'(l);
    s[1*80 +: 16] = 16'(m);
    s[2*80 +: 16] = 16'(h);
    return s;
  endfunction

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [SW-1:0] s);
    cfg_valid = 1'b1; cfg_coeffs = s;
    step();
    cfg_valid = 1'b0;
  endtask

  // idle gap of `gap` cycles, then a single-cycle sample tick
  task automatic tick(input int gap);
    repeat (gap) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(9);
  endtask

  logic [SW-1:0] pass, s1, sa, sb, sc, sd, se, sf, sg, exp_set;

  initial begin
    pass = mk(16384, 16384, 16384);
    s1 = mk(1000, 2000, 3000);
    sa = mk(4000, 4001, 4002);
    sb = mk(5000, 5001, 5002);
    sc = mk(6000, 6001, 6002);
    sd = mk(7000, 7001, 7002);
    se = mk(8000, 8001, 8002);
    sf = mk(9000, 9001, 9002);
    sg = mk(9500, 9501, 9502);

    reset = 1'b0; cfg_valid = 1'b0; cfg_coeffs = '0; sample_tick = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Reset state
    check("rst_coef", coef_active, pass);
    check("rst_busy", SW'(busy), SW'(0));
    check("rst_pending", SW'(pending), SW'(0));
    check("rst_clr", SW'(state_clr), SW'(0));
    check("rst_done", SW'(update_done), SW'(0));
    check("rst_unstable", SW'(unstable), SW'(0));

    // Basic update, ticks every 50 cycles
    cfg(s1);
    check("bas_pending", SW'(pending), SW'(1));
    check("bas_idle", SW'(busy), SW'(0));
    step();
    check("bas_busy", SW'(busy), SW'(1));
    check("bas_pend_clr", SW'(pending), SW'(0));
    tick(49);
    check("bas_t1_clr", SW'(state_clr), SW'(3'b001));
    exp_set = pass; exp_set[0 +: 80] = s1[0 +: 80];
    check("bas_t1_coef", coef_active, exp_set);
    step();
    check("bas_clr_pulse", SW'(state_clr), SW'(0));
    tick(48);
    check("bas_t2_clr", SW'(state_clr), SW'(0));
    tick(49);
    check("bas_t3_clr", SW'(state_clr), SW'(0));
    check("bas_t3_coef", coef_active, exp_set);
    tick(49);
    check("bas_t4_clr", SW'(state_clr), SW'(3'b010));
    exp_set[80 +: 80] = s1[80 +: 80];
    check("bas_t4_coef", coef_active, exp_set);
    tick(49);
    tick(49);
    check("bas_t6_done", SW'(update_done), SW'(0));
    tick(49);
    check("bas_t7_clr", SW'(state_clr), SW'(3'b100));
    check("bas_t7_done", SW'(update_done), SW'(1));
    check("bas_t7_coef", coef_active, s1);
    check("bas_t7_busy", SW'(busy), SW'(0));
    step();
    check("bas_done_pulse", SW'(update_done), SW'(0));

    // Overwrite: A then B while the C sequence is running
    cfg(sc);
    step();
    check("ovw_busy", SW'(busy), SW'(1));
    cfg(sa);
    check("ovw_a_none", SW'(overwrite), SW'(0));
    check("ovw_a_pend", SW'(pending), SW'(1));
    repeat (4) step();
    cfg(sb);
    check("ovw_b_pulse", SW'(overwrite), SW'(1));
    step();
    check("ovw_b_once", SW'(overwrite), SW'(0));
    ticks(7);
    check("ovw_c_done", SW'(update_done), SW'(1));
    check("ovw_c_coef", coef_active, sc);
    check("ovw_c_pend", SW'(pending), SW'(1));
    step();
    check("ovw_b_start", SW'(busy), SW'(1));
    ticks(1);
    exp_set = sc; exp_set[0 +: 80] = sb[0 +: 80];
    check("ovw_b_low", coef_active, exp_set);
    ticks(6);
    check("ovw_b_final", coef_active, sb);

    // Capture coincidence on the IDLE launch edge
    step();
    cfg(sd);
    cfg(se);
    check("coin_busy", SW'(busy), SW'(1));
    check("coin_pend", SW'(pending), SW'(1));
    check("coin_ovw", SW'(overwrite), SW'(0));
    ticks(7);
    check("coin_d_done", SW'(update_done), SW'(1));
    check("coin_d_coef", coef_active, sd);
    step();
    check("coin_e_start", SW'(busy), SW'(1));
    check("coin_e_pend", SW'(pending), SW'(0));
    ticks(7);
    check("coin_e_coef", coef_active, se);

    // Reset mid-sequence after the low commit, with a set pending
    step();
    cfg(sf);
    step();
    ticks(1);
    exp_set = se; exp_set[0 +: 80] = sf[0 +: 80];
    check("rmid_low", coef_active, exp_set);
    cfg(sg);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rmid_coef", coef_active, pass);
    check("rmid_pend", SW'(pending), SW'(0));
    check("rmid_busy", SW'(busy), SW'(0));
    ticks(7);
    check("rmid_nodone", SW'(update_done), SW'(0));
    check("rmid_coef2", coef_active, pass);

`ifdef COEFF_STAB_CHECK_EN
    // Mid band a2 = 1.0 is outside the stability triangle
    exp_set = s1;
    exp_set[80 + 64 +: 16] = 16'd16384;
    cfg(exp_set);
    step();
    ticks(4);
    check("stab_mid_clr", SW'(state_clr), SW'(0));
    check("stab_unstable", SW'(unstable), SW'(3'b010));
    ticks(3);
    check("stab_done", SW'(update_done), SW'(1));
    check("stab_clr_high", SW'(state_clr), SW'(3'b100));
    exp_set = s1; exp_set[80 +: 80] = pass[80 +: 80];
    check("stab_coef", coef_active, exp_set);
`else
    check("stab_off", SW'(unstable), SW'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
